// File: rtl/audio_band_meter.sv
// audio_band_meter
//   Splits each incoming signed audio sample through a cascade of one-pole
//   lowpass sections (one per band, processed one band per clock), tracks a
//   peak-hold envelope with exponential decay per band, and presents a
//   registered output sample plus per-band level meters.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   audio_in   signed sample, taken when ready=1 and the block is idle
//   ready      one-cycle sample strobe
//   controls   [1:0] output mode (00 bypass, 01 mute, 10 lowpass, 11 highpass)
//              [2] level freeze, [7] overrun clear, [6:3] ignored
//   audio_out  processed signed sample (registered)
//   out_valid  one-cycle pulse when audio_out/levels update
//   levels     band k level at [k*LEVEL_W +: LEVEL_W] (registered)
//   busy       high while a sample is being processed
//   overrun    sticky: a strobe arrived while busy and was dropped
module audio_band_meter #(
    parameter int WIDTH       = 18,
    parameter int BANDS       = 7,
    parameter int LEVEL_W     = 8,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           audio_in,
    input  logic                       ready,
    input  logic [7:0]                 controls,
    output logic [WIDTH-1:0]           audio_out,
    output logic                       out_valid,
    output logic [BANDS*LEVEL_W-1:0]   levels,
    output logic                       busy,
    output logic                       overrun
);

    localparam int KW = (BANDS > 1) ? $clog2(BANDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0]            bandIdx_q;
    logic signed [WIDTH-1:0]  sample_q;
    logic signed [WIDTH-1:0]  bandIn_q;
    logic signed [WIDTH-1:0]  lp_q [BANDS];
    logic [WIDTH-2:0]         env_q [BANDS];
    logic [WIDTH-1:0]         audioOut_q;
    logic                     outValid_q;
    logic [BANDS*LEVEL_W-1:0] levels_q;
    logic                     overrun_q;

    logic signed [WIDTH-1:0]  lpCur;
    logic signed [WIDTH-1:0]  lpNew;
    logic signed [WIDTH-1:0]  lpLast;
    logic signed [WIDTH:0]    diff;
    logic signed [WIDTH:0]    diffShifted;
    logic signed [WIDTH:0]    lpSum;
    logic signed [WIDTH:0]    bandSig;
    logic [WIDTH:0]           bandAbs;
    logic [WIDTH:0]           hpDiff;
    logic [WIDTH-2:0]         mag;
    logic [WIDTH-2:0]         envCur;
    logic [WIDTH-2:0]         envNew;
    logic [KW:0]              shiftAmt;
    logic [WIDTH-1:0]         audioNext;
    logic [BANDS*LEVEL_W-1:0] levelsNext;
    logic                     unusedBits;

    // Sequencer: accept a sample in IDLE, walk the bands in RUN, then spend
    // one cycle in DONE publishing the results.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ready) state_d = RUN;
            RUN:     if (bandIdx_q == KW'(BANDS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Per-band arithmetic for the band currently selected by bandIdx_q.
    // The difference is formed one bit wider so it cannot wrap; the new
    // lowpass value always lies between the old value and the input, so
    // dropping back to WIDTH bits is lossless.
    always_comb begin
        lpCur       = lp_q[bandIdx_q];
        envCur      = env_q[bandIdx_q];
        shiftAmt    = (KW+1)'(bandIdx_q) + (KW+1)'(1);
        diff        = {bandIn_q[WIDTH-1], bandIn_q} - {lpCur[WIDTH-1], lpCur};
        diffShifted = diff >>> shiftAmt;
        lpSum       = {lpCur[WIDTH-1], lpCur} + diffShifted;
        lpNew       = lpSum[WIDTH-1:0];
        bandSig     = {bandIn_q[WIDTH-1], bandIn_q} - {lpNew[WIDTH-1], lpNew};
        bandAbs     = bandSig[WIDTH] ? -bandSig : bandSig;
        // Anything at or above 2^(WIDTH-1) pins to the largest positive magnitude.
        mag         = (bandAbs[WIDTH:WIDTH-1] != 2'b00) ? '1 : bandAbs[WIDTH-2:0];
        envNew      = (mag > envCur) ? mag : envCur - (envCur >> DECAY_SHIFT);
    end

    // Output sample selection; highpass clamps instead of wrapping.
    always_comb begin
        lpLast    = lp_q[BANDS-1];
        hpDiff    = {sample_q[WIDTH-1], sample_q} - {lpLast[WIDTH-1], lpLast};
        audioNext = sample_q;
        case (controls[1:0])
            2'b00: audioNext = sample_q;
            2'b01: audioNext = '0;
            2'b10: audioNext = lpLast;
            default: begin
                if (hpDiff[WIDTH] != hpDiff[WIDTH-1])
                    audioNext = hpDiff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    audioNext = hpDiff[WIDTH-1:0];
            end
        endcase
    end

    // Meter value per band is the top LEVEL_W bits of its envelope.
    always_comb begin
        levelsNext = '0;
        for (int k = 0; k < BANDS; k++)
            levelsNext[k*LEVEL_W +: LEVEL_W] = env_q[k][WIDTH-2 -: LEVEL_W];
    end

    // Datapath registers. The overrun flag is evaluated ahead of the state
    // case so a strobe during RUN or DONE is recorded without disturbing the
    // sample already in flight; a new overrun beats a same-cycle clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            bandIdx_q  <= '0;
            sample_q   <= '0;
            bandIn_q   <= '0;
            audioOut_q <= '0;
            outValid_q <= 1'b0;
            levels_q   <= '0;
            overrun_q  <= 1'b0;
            for (int k = 0; k < BANDS; k++) begin
                lp_q[k]  <= '0;
                env_q[k] <= '0;
            end
        end else begin
            outValid_q <= 1'b0;
            if (ready && busy)
                overrun_q <= 1'b1;
            else if (controls[7])
                overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready) begin
                        sample_q  <= audio_in;
                        bandIn_q  <= audio_in;
                        bandIdx_q <= '0;
                    end
                end
                RUN: begin
                    lp_q[bandIdx_q]  <= lpNew;
                    env_q[bandIdx_q] <= envNew;
                    bandIn_q         <= lpNew;
                    if (bandIdx_q != KW'(BANDS - 1))
                        bandIdx_q <= bandIdx_q + KW'(1);
                end
                DONE: begin
                    audioOut_q <= audioNext;
                    outValid_q <= 1'b1;
                    if (!controls[2])
                        levels_q <= levelsNext;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign audio_out  = audioOut_q;
    assign out_valid  = outValid_q;
    assign levels     = levels_q;
    assign overrun    = overrun_q;
    assign unusedBits = ^{controls[6:3], lpSum[WIDTH]};

endmodule

// File: tb/tb_audio_band_meter.sv
// tb_audio_band_meter
//   Directed test of audio_band_meter with a sample-level reference model.
//   The model computes every band's lowpass/envelope update in one go when a
//   sample is accepted and schedules the result for the cycle the outputs are
//   due; a negedge process compares all outputs against it every cycle.
module tb_audio_band_meter;

    localparam int WIDTH       = 18;
    localparam int BANDS       = 7;
    localparam int LEVEL_W     = 8;
    localparam int DECAY_SHIFT = 4;
    localparam longint MAXV    = (longint'(1) << (WIDTH - 1)) - 1;
    localparam longint MINV    = -MAXV - 1;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [WIDTH-1:0]         audio_in;
    logic                     ready;
    logic [7:0]               controls;
    logic [WIDTH-1:0]         audio_out;
    logic                     out_valid;
    logic [BANDS*LEVEL_W-1:0] levels;
    logic                     busy;
    logic                     overrun;

    int total = 0;
    int bad   = 0;

    audio_band_meter #(
        .WIDTH(WIDTH), .BANDS(BANDS), .LEVEL_W(LEVEL_W), .DECAY_SHIFT(DECAY_SHIFT)
    ) dut (
        .clock(clock), .reset(reset), .audio_in(audio_in), .ready(ready),
        .controls(controls), .audio_out(audio_out), .out_valid(out_valid),
        .levels(levels), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Reference model state.
    longint                   mLp [BANDS];
    longint                   mEnv [BANDS];
    longint                   mX;
    longint                   mAudio;
    logic [BANDS*LEVEL_W-1:0] mLevels;
    bit                       mValid;
    bit                       mOverrun;
    int                       mBusy;
    bit                       checkEn = 1'b0;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void modelClear();
        for (int k = 0; k < BANDS; k++) begin
            mLp[k]  = 0;
            mEnv[k] = 0;
        end
        mX = 0; mAudio = 0; mLevels = '0; mValid = 0; mOverrun = 0; mBusy = 0;
    endfunction

    // All bands for one sample: each stage is a one-pole lowpass whose input
    // is the previous stage's fresh output; the band signal is what the stage
    // removed, and its magnitude feeds a peak-hold envelope.
    function automatic void modelBands(input longint x);
        longint inK, lpn, b, mag;
        inK = x;
        for (int k = 0; k < BANDS; k++) begin
            lpn = mLp[k] + ((inK - mLp[k]) >>> (k + 1));
            b   = inK - lpn;
            mag = (b < 0) ? -b : b;
            if (mag > MAXV) mag = MAXV;
            if (mag > mEnv[k]) mEnv[k] = mag;
            else               mEnv[k] = mEnv[k] - (mEnv[k] >> DECAY_SHIFT);
            mLp[k] = lpn;
            inK    = lpn;
        end
    endfunction

    function automatic void modelPublish(input logic [7:0] ctrl);
        longint d;
        case (ctrl[1:0])
            2'b00: mAudio = mX;
            2'b01: mAudio = 0;
            2'b10: mAudio = mLp[BANDS-1];
            default: begin
                d = mX - mLp[BANDS-1];
                if (d > MAXV) d = MAXV;
                if (d < MINV) d = MINV;
                mAudio = d;
            end
        endcase
        if (!ctrl[2])
            for (int k = 0; k < BANDS; k++)
                mLevels[k*LEVEL_W +: LEVEL_W] = LEVEL_W'(mEnv[k] >> (WIDTH - 1 - LEVEL_W));
        mValid = 1;
    endfunction

    // Timing model: a sample accepted on an edge occupies the block for
    // BANDS+1 further edges and is published on the last of them.
    always @(posedge clock) begin
        if (reset) begin
            modelClear();
        end else begin
            mValid = 0;
            if (ready && mBusy > 0)  mOverrun = 1;
            else if (controls[7])    mOverrun = 0;
            if (mBusy == 0) begin
                if (ready) begin
                    mX = longint'($signed(audio_in));
                    modelBands(mX);
                    mBusy = BANDS + 1;
                end
            end else begin
                mBusy--;
                if (mBusy == 0) modelPublish(controls);
            end
        end
    end

    always @(negedge clock) begin
        logic [WIDTH-1:0] expAudio;
        if (checkEn) begin
            expAudio = mAudio[WIDTH-1:0];
            checkVal("busy", busy, mBusy > 0);
            checkVal("out_valid", out_valid, mValid);
            checkVal("overrun", overrun, mOverrun);
            checkVal("audio_out", audio_out, expAudio);
            checkVal("levels", levels, mLevels);
        end
    end

    // Strobe one sample with ctrlA, switch to ctrlB once it is accepted, and
    // return on the negedge just before the publishing edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] s, input logic [7:0] ctrlA,
                                 input logic [7:0] ctrlB);
        @(negedge clock);
        audio_in = s;
        ready    = 1'b1;
        controls = ctrlA;
        @(negedge clock);
        ready    = 1'b0;
        controls = ctrlB;
        repeat (BANDS) @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] expAudio);
        checkVal({name, "_early"}, out_valid, 1'b0);
        @(negedge clock);
        checkVal({name, "_valid"}, out_valid, 1'b1);
        checkVal({name, "_audio"}, audio_out, expAudio);
        checkVal({name, "_idle"}, busy, 1'b0);
        @(negedge clock);
        checkVal({name, "_pulse"}, out_valid, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [BANDS*LEVEL_W-1:0] snap;
        logic signed [WIDTH-1:0]  aoS;
        bit                       sawValid;

        reset = 1'b1; ready = 1'b0; audio_in = '0; controls = 8'h00;
        repeat (2) @(negedge clock);
        checkEn = 1'b1;

        // A strobe during reset must be ignored.
        ready = 1'b1; audio_in = 18'h00123;
        @(negedge clock);
        ready = 1'b0; reset = 1'b0;
        checkVal("rst_busy", busy, 1'b0);
        checkVal("rst_audio", audio_out, 0);
        checkVal("rst_levels", levels, 0);
        checkVal("rst_overrun", overrun, 1'b0);

        // Bypass, mute, and a mode change after acceptance.
        applyStimulus(18'h00100, 8'h00, 8'h00);
        checkOutput("bypass", 18'h00100);
        checkVal("bypass_levels", levels, 0);
        applyStimulus(18'h01234, 8'h01, 8'h01);
        checkOutput("mute", 18'h00000);
        applyStimulus(18'h00777, 8'h01, 8'h00);
        checkOutput("late_mode", 18'h00777);

        // Full-scale alternating input in highpass mode from a clean state.
        doReset();
        applyStimulus(18'h1FFFF, 8'h03, 8'h03);
        checkOutput("hp_pos", 18'h1FFFF);
        checkVal("lvl0_first", levels[7:0], 8'h80);
        applyStimulus(18'h20001, 8'h03, 8'h03);
        checkOutput("hp_neg", 18'h20001);
        checkVal("lvl0_second", levels[7:0], 8'hBF);
        for (int i = 0; i < 20; i++)
            applyStimulus((i % 2 == 0) ? 18'h1FFFF : 18'h20001, 8'h03, 8'h03);
        @(negedge clock);
        checkVal("lvl_live", levels != 0, 1'b1);

        // Freeze, feed silence, then release.
        snap = mLevels;
        for (int i = 0; i < 50; i++)
            applyStimulus(18'h00000, 8'h07, 8'h07);
        @(negedge clock);
        checkVal("freeze_hold", levels, snap);
        applyStimulus(18'h00000, 8'h03, 8'h03);
        @(negedge clock);
        checkVal("unfreeze_valid", out_valid, 1'b1);
        checkVal("unfreeze_changed", levels != snap, 1'b1);

        // Overrun: second strobe two edges after the first.
        @(negedge clock);
        audio_in = 18'h00055; ready = 1'b1; controls = 8'h00;
        @(negedge clock);
        ready = 1'b0;
        @(negedge clock);
        audio_in = 18'h3FFFF; ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        checkVal("ovr_set", overrun, 1'b1);
        repeat (BANDS - 1) @(negedge clock);
        checkVal("ovr_valid", out_valid, 1'b1);
        checkVal("ovr_audio", audio_out, 18'h00055);
        @(negedge clock);
        controls = 8'h80;
        @(negedge clock);
        controls = 8'h00;
        checkVal("ovr_clear", overrun, 1'b0);

        // New overrun beats a same-cycle clear.
        @(negedge clock);
        audio_in = 18'h00321; ready = 1'b1;
        @(negedge clock);
        controls = 8'h80;
        @(negedge clock);
        ready = 1'b0; controls = 8'h00;
        checkVal("ovr_prio", overrun, 1'b1);
        repeat (BANDS) @(negedge clock);
        @(negedge clock);
        controls = 8'h80;
        @(negedge clock);
        controls = 8'h00;

        // Strobe in the publishing cycle is an overrun; the next one is taken.
        @(negedge clock);
        audio_in = 18'h00400; ready = 1'b1;
        @(negedge clock);
        ready = 1'b0;
        repeat (BANDS) @(negedge clock);
        ready = 1'b1; audio_in = 18'h00500;
        @(negedge clock);
        checkVal("ovr_done", overrun, 1'b1);
        checkVal("done_valid", out_valid, 1'b1);
        audio_in = 18'h00600;
        @(negedge clock);
        ready = 1'b0;
        checkVal("accept_after_done", busy, 1'b1);
        repeat (BANDS + 2) @(negedge clock);
        controls = 8'h80;
        @(negedge clock);
        controls = 8'h00;

        // Lowpass mode with a constant input.
        doReset();
        for (int i = 0; i < 150; i++)
            applyStimulus(18'd1000, 8'h02, 8'h02);
        @(negedge clock);
        aoS = audio_out;
        checkVal("lp_valid", out_valid, 1'b1);
        checkVal("lp_bounded", (aoS > 0) && (aoS <= 1000), 1'b1);
        checkVal("lp_levels_zero", levels, 0);

        // Highpass saturation, negative side (lowpass output is positive).
        applyStimulus(18'h20000, 8'h03, 8'h03);
        checkOutput("hp_sat_neg", 18'h20000);

        // Drive the lowpass strongly negative, then positive saturation.
        for (int i = 0; i < 200; i++)
            applyStimulus(18'h27960, 8'h02, 8'h02);
        applyStimulus(18'h1FFFF, 8'h03, 8'h03);
        checkOutput("hp_sat_pos", 18'h1FFFF);

        // Reset while the fourth band is being processed.
        @(negedge clock);
        audio_in = 18'h01111; ready = 1'b1; controls = 8'h00;
        @(negedge clock);
        ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkVal("midrst_busy", busy, 1'b0);
        checkVal("midrst_audio", audio_out, 0);
        checkVal("midrst_levels", levels, 0);
        checkVal("midrst_valid", out_valid, 1'b0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            sawValid |= out_valid;
        end
        checkVal("midrst_no_valid", sawValid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
